// File: rtl/apb_periph_demux.sv
// rtl/apb_periph_demux.sv - registered APB 1-to-N peripheral demux with decode/timeout error reporting
module apb_periph_demux #(
    parameter int NB_SLAVE       = 12,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter logic [NB_SLAVE-1:0][ADDR_WIDTH-1:0] START_ADDR = '0,
    parameter logic [NB_SLAVE-1:0][ADDR_WIDTH-1:0] END_ADDR   = '0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [ADDR_WIDTH-1:0]          paddr_i,
    input  logic [DATA_WIDTH-1:0]          pwdata_i,
    input  logic                           pwrite_i,
    input  logic                           psel_i,
    input  logic                           penable_i,
    output logic [DATA_WIDTH-1:0]          prdata_o,
    output logic                           pready_o,
    output logic                           pslverr_o,
    output logic [ADDR_WIDTH-1:0]          paddr_o,
    output logic [DATA_WIDTH-1:0]          pwdata_o,
    output logic                           pwrite_o,
    output logic                           penable_o,
    output logic [NB_SLAVE-1:0]            psel_o,
    input  logic [NB_SLAVE*DATA_WIDTH-1:0] prdata_i,
    input  logic [NB_SLAVE-1:0]            pready_i,
    input  logic [NB_SLAVE-1:0]            pslverr_i,
    output logic                           err_valid_o,
    output logic [1:0]                     err_code_o,
    output logic [ADDR_WIDTH-1:0]          err_addr_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_DECODE  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_SLAVE   = 2'b11;

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [1:0]            state_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic                  pwrite_q;
    logic [NB_SLAVE-1:0]   sel_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            err_q;

    logic [NB_SLAVE-1:0]   dec_sel;
    logic                  sel_ready;
    logic                  sel_slverr;
    logic [DATA_WIDTH-1:0] sel_rdata;
    logic                  timeout_hit;

    // Walk from the top down so the lowest matching region is the last one written.
    always_comb begin
        dec_sel = '0;
        for (int k = NB_SLAVE - 1; k >= 0; k--) begin
            if ((paddr_i >= START_ADDR[k]) && (paddr_i <= END_ADDR[k])) begin
                dec_sel    = '0;
                dec_sel[k] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_rdata = '0;
        for (int k = 0; k < NB_SLAVE; k++) begin
            sel_rdata = sel_rdata | (prdata_i[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{sel_q[k]}});
        end
    end

    assign sel_ready   = |(pready_i & sel_q);
    assign sel_slverr  = |(pslverr_i & sel_q);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            sel_q    <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            err_q    <= ERR_NONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (psel_i && !penable_i) begin
                        paddr_q  <= paddr_i;
                        pwdata_q <= pwdata_i;
                        pwrite_q <= pwrite_i;
                        sel_q    <= dec_sel;
                        rdata_q  <= '0;
                        if (|dec_sel) begin
                            err_q   <= ERR_NONE;
                            state_q <= ST_SETUP;
                        end else begin
                            err_q   <= ERR_DECODE;
                            state_q <= ST_RESP;
                        end
                    end
                end
                ST_SETUP: begin
                    cnt_q   <= '0;
                    state_q <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // A ready arriving on the last allowed cycle still completes normally.
                    if (sel_ready) begin
                        rdata_q <= sel_rdata;
                        err_q   <= sel_slverr ? ERR_SLAVE : ERR_NONE;
                        state_q <= ST_RESP;
                    end else if (timeout_hit) begin
                        err_q   <= ERR_TIMEOUT;
                        state_q <= ST_RESP;
                    end else if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign psel_o      = ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) ? sel_q : '0;
    assign penable_o   = (state_q == ST_ACCESS);
    assign paddr_o     = paddr_q;
    assign pwdata_o    = pwdata_q;
    assign pwrite_o    = pwrite_q;

    assign pready_o    = (state_q == ST_RESP);
    assign pslverr_o   = pready_o && (err_q != ERR_NONE);
    assign prdata_o    = pready_o ? rdata_q : '0;

    assign err_valid_o = pslverr_o;
    assign err_code_o  = err_valid_o ? err_q : ERR_NONE;
    assign err_addr_o  = err_valid_o ? paddr_q : '0;

endmodule

// File: tb/tb_apb_periph_demux.sv
// tb/tb_apb_periph_demux.sv - directed self-checking bench for apb_periph_demux
module tb_apb_periph_demux;

    localparam int NB = 12;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    // Slot 5 deliberately overlaps slots 1..4 so the lowest-index priority is exercised.
    localparam logic [NB-1:0][AW-1:0] START_MAP = {
        32'hB000, 32'hA000, 32'h9000, 32'h8000, 32'h7000, 32'h6000,
        32'h1000, 32'h4000, 32'h3000, 32'h2000, 32'h1000, 32'h0000};
    localparam logic [NB-1:0][AW-1:0] END_MAP = {
        32'hBFFF, 32'hAFFF, 32'h9FFF, 32'h8FFF, 32'h7FFF, 32'h6FFF,
        32'h5FFF, 32'h4FFF, 32'h3FFF, 32'h2FFF, 32'h1FFF, 32'h0FFF};

    logic              clk = 1'b0;
    logic              rst_i;
    logic [AW-1:0]     paddr_i;
    logic [DW-1:0]     pwdata_i;
    logic              pwrite_i;
    logic              psel_i;
    logic              penable_i;
    logic [DW-1:0]     prdata_o;
    logic              pready_o;
    logic              pslverr_o;
    logic [AW-1:0]     paddr_o;
    logic [DW-1:0]     pwdata_o;
    logic              pwrite_o;
    logic              penable_o;
    logic [NB-1:0]     psel_o;
    logic [NB*DW-1:0]  prdata_s;
    logic [NB-1:0]     pready_s;
    logic [NB-1:0]     pslverr_s;
    logic              err_valid_o;
    logic [1:0]        err_code_o;
    logic [AW-1:0]     err_addr_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0]    acc_cnt = 4'd0;
    logic [3:0]    wait_n = 4'd0;
    logic          never_rdy = 1'b0;
    logic [NB-1:0] err_mask = '0;
    logic [NB-1:0] force_rdy = '0;

    apb_periph_demux #(
        .NB_SLAVE(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO),
        .START_ADDR(START_MAP), .END_ADDR(END_MAP)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .paddr_i(paddr_i), .pwdata_i(pwdata_i), .pwrite_i(pwrite_i),
        .psel_i(psel_i), .penable_i(penable_i),
        .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
        .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pwrite_o(pwrite_o),
        .penable_o(penable_o), .psel_o(psel_o),
        .prdata_i(prdata_s), .pready_i(pready_s), .pslverr_i(pslverr_s),
        .err_valid_o(err_valid_o), .err_code_o(err_code_o), .err_addr_o(err_addr_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (penable_o && ((pready_s & psel_o) == '0)) acc_cnt <= acc_cnt + 4'd1;
        else acc_cnt <= 4'd0;
    end

    always_comb begin
        pready_s = force_rdy;
        if (penable_o && !never_rdy && (acc_cnt == wait_n)) pready_s = pready_s | psel_o;
        pslverr_s = pready_s & err_mask;
        prdata_s = '0;
        for (int k = 0; k < NB; k++) prdata_s[k*DW +: DW] = 32'hCAFE0000 | 32'(k);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apb_xfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata,
                            output logic [DW-1:0] rdata, output logic slverr, output int lat,
                            output logic ev, output logic [1:0] code, output logic [AW-1:0] eaddr,
                            output logic [NB-1:0] psel_or, output int psel_cyc, output logic bus_ok);
        logic done;
        paddr_i = addr; pwrite_i = wr; pwdata_i = wdata; psel_i = 1'b1; penable_i = 1'b0;
        lat = 0; psel_or = '0; psel_cyc = 0; bus_ok = 1'b1; done = 1'b0;
        rdata = '0; slverr = 1'b0; ev = 1'b0; code = 2'b00; eaddr = '0;
        @(posedge clk); #1 penable_i = 1'b1;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (psel_o != '0) begin
                psel_or = psel_or | psel_o;
                psel_cyc++;
                if (paddr_o !== addr || pwrite_o !== wr || pwdata_o !== wdata) bus_ok = 1'b0;
            end
            if (pready_o) begin
                rdata = prdata_o; slverr = pslverr_o; ev = err_valid_o;
                code = err_code_o; eaddr = err_addr_o; done = 1'b1;
                break;
            end
        end
        if (!done) check_eq("xfer_no_pready", 64'(done), 64'd1);
        @(posedge clk); #1 psel_i = 1'b0; penable_i = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] rd;
        logic          se, ev, bok, saw;
        logic [1:0]    cd;
        logic [AW-1:0] ea;
        logic [NB-1:0] por;
        int            lat, pcyc, ndone;

        rst_i = 1'b1; paddr_i = '0; pwdata_i = '0; pwrite_i = 1'b0; psel_i = 1'b0; penable_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        check_eq("rst_psel", 64'(psel_o), 64'd0);
        check_eq("rst_pready", 64'(pready_o), 64'd0);
        check_eq("rst_penable", 64'(penable_o), 64'd0);
        check_eq("rst_err_valid", 64'(err_valid_o), 64'd0);
        check_eq("rst_paddr", 64'(paddr_o), 64'd0);

        // Read slave 3, ready on the first ACCESS cycle
        wait_n = 4'd0;
        apb_xfer(32'h3010, 1'b0, 32'h0, rd, se, lat, ev, cd, ea, por, pcyc, bok);
        check_eq("rd3_lat", 64'(lat), 64'd3);
        check_eq("rd3_psel", 64'(por), 64'h008);
        check_eq("rd3_psel_cycles", 64'(pcyc), 64'd2);
        check_eq("rd3_rdata", 64'(rd), 64'hCAFE0003);
        check_eq("rd3_slverr", 64'(se), 64'd0);
        check_eq("rd3_bus_stable", 64'(bok), 64'd1);

        // Unmapped write
        apb_xfer(32'hF000_0000, 1'b1, 32'h1234_5678, rd, se, lat, ev, cd, ea, por, pcyc, bok);
        check_eq("dec_lat", 64'(lat), 64'd1);
        check_eq("dec_psel", 64'(por), 64'd0);
        check_eq("dec_slverr", 64'(se), 64'd1);
        check_eq("dec_err_valid", 64'(ev), 64'd1);
        check_eq("dec_code", 64'(cd), 64'd1);
        check_eq("dec_addr", 64'(ea), 64'hF000_0000);
        check_eq("dec_rdata", 64'(rd), 64'd0);

        // Timeout: slave 4 never ready
        never_rdy = 1'b1;
        apb_xfer(32'h4000, 1'b0, 32'h0, rd, se, lat, ev, cd, ea, por, pcyc, bok);
        check_eq("to_lat", 64'(lat), 64'd6);
        check_eq("to_psel_cycles", 64'(pcyc), 64'd5);
        check_eq("to_slverr", 64'(se), 64'd1);
        check_eq("to_code", 64'(cd), 64'd2);
        check_eq("to_rdata", 64'(rd), 64'd0);
        check_eq("to_addr", 64'(ea), 64'h4000);
        saw = 1'b0;
        @(posedge clk); #1 force_rdy[4] = 1'b1;
        @(negedge clk); saw = saw | pready_o | (psel_o != '0);
        @(posedge clk); #1 force_rdy = '0;
        repeat (3) begin @(negedge clk); saw = saw | pready_o | (psel_o != '0); end
        check_eq("to_late_ready_ignored", 64'(saw), 64'd0);
        never_rdy = 1'b0;

        // Ready exactly on ACCESS cycle TO
        wait_n = 4'd3;
        apb_xfer(32'h4008, 1'b0, 32'h0, rd, se, lat, ev, cd, ea, por, pcyc, bok);
        check_eq("edge_lat", 64'(lat), 64'd6);
        check_eq("edge_slverr", 64'(se), 64'd0);
        check_eq("edge_err_valid", 64'(ev), 64'd0);
        check_eq("edge_rdata", 64'(rd), 64'hCAFE0004);

        wait_n = 4'd1;
        apb_xfer(32'h2000, 1'b1, 32'hA5A5_0001, rd, se, lat, ev, cd, ea, por, pcyc, bok);
        check_eq("wait1_lat", 64'(lat), 64'd4);
        check_eq("wait1_bus_stable", 64'(bok), 64'd1);
        wait_n = 4'd0;

        // Slave error from slave 7
        err_mask[7] = 1'b1;
        apb_xfer(32'h7FFC, 1'b0, 32'h0, rd, se, lat, ev, cd, ea, por, pcyc, bok);
        check_eq("serr_slverr", 64'(se), 64'd1);
        check_eq("serr_code", 64'(cd), 64'd3);
        check_eq("serr_err_valid", 64'(ev), 64'd1);
        check_eq("serr_rdata", 64'(rd), 64'hCAFE0007);
        err_mask = '0;

        // Overlap of slots 1 and 5
        apb_xfer(32'h1800, 1'b0, 32'h0, rd, se, lat, ev, cd, ea, por, pcyc, bok);
        check_eq("ovl_psel", 64'(por), 64'h002);
        check_eq("ovl_rdata", 64'(rd), 64'hCAFE0001);

        // Reset during ACCESS
        never_rdy = 1'b1;
        paddr_i = 32'h6000; pwrite_i = 1'b1; pwdata_i = 32'h55; psel_i = 1'b1; penable_i = 1'b0;
        @(posedge clk); #1 penable_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("rstmid_in_access", 64'(penable_o), 64'd1);
        rst_i = 1'b1;
        @(posedge clk); #1 rst_i = 1'b0; psel_i = 1'b0; penable_i = 1'b0;
        @(negedge clk);
        check_eq("rstmid_outputs", 64'({psel_o, penable_o, pready_o, pslverr_o, err_valid_o, err_code_o}), 64'd0);
        check_eq("rstmid_bus", 64'({prdata_o, pwrite_o} | {paddr_o, 1'b0} | {pwdata_o, 1'b0} | {err_addr_o, 1'b0}), 64'd0);
        saw = 1'b0;
        repeat (3) begin @(negedge clk); saw = saw | pready_o; end
        check_eq("rstmid_no_response", 64'(saw), 64'd0);
        never_rdy = 1'b0;
        apb_xfer(32'h2004, 1'b0, 32'h0, rd, se, lat, ev, cd, ea, por, pcyc, bok);
        check_eq("rstmid_after_rdata", 64'(rd), 64'hCAFE0002);
        check_eq("rstmid_after_lat", 64'(lat), 64'd3);

        // Back-to-back reads
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            apb_xfer(32'(i) * 32'h1000 + 32'h4, 1'b0, 32'h0, rd, se, lat, ev, cd, ea, por, pcyc, bok);
            check_eq($sformatf("b2b_rdata_%0d", i), 64'(rd), 64'hCAFE0000 | 64'(i));
            if (lat == 3 && !se) ndone++;
        end
        check_eq("b2b_done", 64'(ndone), 64'd10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
